cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, giving the word-address width ({tag[2:0], index[11:0]}).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the words per refill (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  1  cache miss request.
REQ-007 req_addr  input  ADDR_W  miss word address (burst base).
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 mem_addr  output  ADDR_W  registered read address to the memory (1-cycle read latency).
REQ-010 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_addr is sampled.
REQ-011 fill_valid  output  1  fill_addr/fill_data are a valid cache write this cycle.
REQ-012 fill_addr  output  ADDR_W  word address being filled.
REQ-013 fill_data  output  DATA_W  word being filled (equals mem_rdata).
REQ-014 busy  output  1  burst in progress (state != IDLE).
REQ-015 done  output  1  one-cycle pulse coincident with the last fill word.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: request accepted at cycle T when req_valid && req_ready; req_addr captured as base; FSM -> ISSUE.
REQ-018 In ISSUE, beat k (0..BURST_LEN-1) SHALL drive mem_addr = base + k during cycle T+1+k.
REQ-019 Address arithmetic SHALL be modulo 2^ADDR_W (0x7FFF + 1 -> 0x0000); no carry beyond ADDR_W.
REQ-020 After beat BURST_LEN-1, FSM SHALL go ISSUE -> DRAIN; DRAIN -> IDLE after one cycle.
REQ-021 fill_valid SHALL be 1 during cycles T+2 .. T+1+BURST_LEN, with fill_addr = address issued in the previous cycle and fill_data = mem_rdata.
REQ-022 done SHALL pulse in cycle T+1+BURST_LEN (DRAIN) only; req_ready returns to 1 at T+2+BURST_LEN.
REQ-023 req_valid while busy SHALL be ignored, not queued; requester must hold it.
REQ-024 Beat counter SHALL be $clog2(BURST_LEN) bits; no beat skipped or repeated.
REQ-025 mem_addr SHALL hold its last value when idle; fill_addr/fill_data are don't-care when fill_valid = 0.

Reset
REQ-026 On rst_n = 0 (any time): FSM = IDLE, beat counter = 0, mem_addr = 0, fill_valid = 0, done = 0, busy = 0, req_ready = 1 on deassertion.
REQ-027 Reset mid-burst SHALL abort it immediately: no further fill_valid or done for that burst.
REQ-028 The first request SHALL be accepted in the first cycle req_valid is high after rst_n deasserts.

Structure
REQ-029 ADDR_W, DATA_W, BURST_LEN defaults and the state enum (IDLE, ISSUE, DRAIN) SHALL live in shared package cache_pkg.
REQ-030 No sub-module in RTL; the bench SHALL instantiate the existing 1-cycle-latency memory model as the mem_addr/mem_rdata responder.

Verification
REQ-031 Req 0x0010 after reset -> mem_addr 0x0010..0x0013 in T+1..T+4; fill_valid T+2..T+5 with matching addr/data; done at T+5 only.
REQ-032 Req 0x7FFE -> fill addrs 0x7FFE, 0x7FFF, 0x0000, 0x0001; no fill outside that range.
REQ-033 req_valid held high across a burst at 0x1000 then 0x2000 -> second accepted at T+6, no beat overlap, req_ready 0 during T+1..T+5.
REQ-034 rst_n low at T+3 of a burst -> fill_valid and done 0 same cycle; no done afterwards; new req 0x0040 then completes normally.
REQ-035 BURST_LEN = 8, req 0x0100 -> 8 fills 0x0100..0x0107, done at T+9.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared defaults and FSM state type for the cache refill controller.
// Imported by the refill controller and anything that needs its widths.
package cache_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache line refill sequencer: issues a burst of word reads to a
// 1-cycle-latency memory and streams the returned words into the cache.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BURST_LEN - 1);

  state_e            state;
  logic [BEAT_W-1:0] beat;

  // Memory returns data for the address issued one cycle earlier,
  // so the registered fill_addr lines up with the raw read data.
  assign fill_data = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      fill_valid <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ISSUE;
            mem_addr  <= req_addr;
            beat      <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        ISSUE: begin
          fill_valid <= 1'b1;
          fill_addr  <= mem_addr;
          if (beat == LAST) begin
            state <= DRAIN;
            done  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            beat     <= beat + BEAT_W'(1);
          end
        end
        DRAIN: begin
          state     <= IDLE;
          beat      <= '0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: 4-beat and 8-beat instances driven by
// random bursts, each cycle compared against a schedule model.
module tb_cache_refill_ctrl;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int M  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  int            sel;
  logic [31:0]   seed;

  logic          rv4, rr4, fv4, bz4, dn4;
  logic [AW-1:0] ma4, fa4;
  logic [DW-1:0] rd4, fd4;
  logic          rv8, rr8, fv8, bz8, dn8;
  logic [AW-1:0] ma8, fa8;
  logic [DW-1:0] rd8, fd8;

  logic          c_ready, c_fv, c_busy, c_done;
  logic [AW-1:0] c_maddr, c_faddr;
  logic [DW-1:0] c_fdata;

  int n_cmp;
  int n_err;

  cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_addr(req_addr),
    .req_ready(rr4), .mem_addr(ma4), .mem_rdata(rd4),
    .fill_valid(fv4), .fill_addr(fa4), .fill_data(fd4),
    .busy(bz4), .done(dn4)
  );

  cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv8), .req_addr(req_addr),
    .req_ready(rr8), .mem_addr(ma8), .mem_rdata(rd8),
    .fill_valid(fv8), .fill_addr(fa8), .fill_data(fd8),
    .busy(bz8), .done(dn8)
  );

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ seed;
  endfunction

  // 1-cycle-latency memory responders
  always_ff @(posedge clk) rd4 <= memfn(ma4);
  always_ff @(posedge clk) rd8 <= memfn(ma8);

  assign rv4 = req_valid && (sel == 0);
  assign rv8 = req_valid && (sel == 1);

  always_comb begin
    c_ready = rr4;
    c_fv    = fv4;
    c_busy  = bz4;
    c_done  = dn4;
    c_maddr = ma4;
    c_faddr = fa4;
    c_fdata = fd4;
    if (sel == 1) begin
      c_ready = rr8;
      c_fv    = fv8;
      c_busy  = bz8;
      c_done  = dn8;
      c_maddr = ma8;
      c_faddr = fa8;
      c_fdata = fd8;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] wrap(input int v);
    return AW'(v % M);
  endfunction

  // Caller sits at a negedge; returns at the negedge where ready is back.
  task automatic do_burst(input logic [AW-1:0] b, input bit hold,
                          input logic [AW-1:0] nb, output int waited);
    int bl;
    logic [AW-1:0] ea;
    bl = (sel == 1) ? 8 : 4;
    req_valid = 1'b1;
    req_addr  = b;
    waited    = 0;
    while (!c_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!c_ready) begin
      n_err++;
      $display("FAIL accept_timeout base=%h ready=%b required 1", b, c_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= bl + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) req_addr = nb;
        else req_valid = 1'b0;
      end
      ea = (k <= bl) ? wrap(int'(b) + k - 1) : wrap(int'(b) + bl - 1);
      n_cmp++;
      if (c_maddr !== ea) begin
        n_err++;
        $display("FAIL mem_addr k=%0d got %h required %h", k, c_maddr, ea);
      end
      n_cmp++;
      if (c_fv !== (k >= 2 && k <= bl + 1)) begin
        n_err++;
        $display("FAIL fill_valid k=%0d got %b required %b",
                 k, c_fv, (k >= 2 && k <= bl + 1));
      end
      if (k >= 2 && k <= bl + 1) begin
        ea = wrap(int'(b) + k - 2);
        n_cmp++;
        if (c_faddr !== ea) begin
          n_err++;
          $display("FAIL fill_addr k=%0d got %h required %h", k, c_faddr, ea);
        end
        n_cmp++;
        if (c_fdata !== memfn(ea)) begin
          n_err++;
          $display("FAIL fill_data k=%0d got %h required %h",
                   k, c_fdata, memfn(ea));
        end
      end
      n_cmp++;
      if (c_done !== (k == bl + 1)) begin
        n_err++;
        $display("FAIL done k=%0d got %b required %b", k, c_done, (k == bl + 1));
      end
      n_cmp++;
      if (c_ready !== (k == bl + 2)) begin
        n_err++;
        $display("FAIL req_ready k=%0d got %b required %b",
                 k, c_ready, (k == bl + 2));
      end
      n_cmp++;
      if (c_busy !== (k <= bl + 1)) begin
        n_err++;
        $display("FAIL busy k=%0d got %b required %b", k, c_busy, (k <= bl + 1));
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rr4, bz4, fv4, dn4} !== 4'b1000 || ma4 !== '0) begin
      n_err++;
      $display("FAIL reset4 got rdy/bsy/fv/dn=%b%b%b%b addr=%h required 1000 0",
               rr4, bz4, fv4, dn4, ma4);
    end
    n_cmp++;
    if ({rr8, bz8, fv8, dn8} !== 4'b1000 || ma8 !== '0) begin
      n_err++;
      $display("FAIL reset8 got rdy/bsy/fv/dn=%b%b%b%b addr=%h required 1000 0",
               rr8, bz8, fv8, dn8, ma8);
    end
  endtask

  task automatic test_basic();
    int w;
    sel = 0;
    do_burst(15'h0010, 1'b0, '0, w);
    n_cmp++;
    if (w != 0) begin
      n_err++;
      $display("FAIL first_accept_wait got %0d required 0", w);
    end
  endtask

  task automatic test_wrap();
    sel = 0;
    begin
      int w;
      do_burst(15'h7FFE, 1'b0, '0, w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    sel = 0;
    do_burst(15'h1000, 1'b1, 15'h2000, w);
    do_burst(15'h2000, 1'b0, '0, w);
    n_cmp++;
    if (w != 0) begin
      n_err++;
      $display("FAIL b2b_accept_wait got %0d required 0", w);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    sel = 0;
    req_valid = 1'b1;
    req_addr  = 15'h0300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fv4, dn4, bz4, rr4} !== 4'b0001 || ma4 !== '0) begin
      n_err++;
      $display("FAIL mid_reset got fv/dn/bsy/rdy=%b%b%b%b addr=%h required 0001 0",
               fv4, dn4, bz4, rr4, ma4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (fv4 !== 1'b0 || dn4 !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_quiet c=%0d got fv=%b dn=%b required 0 0",
                 i, fv4, dn4);
      end
    end
    do_burst(15'h0040, 1'b0, '0, w);
    n_cmp++;
    if (w != 0) begin
      n_err++;
      $display("FAIL post_reset_accept_wait got %0d required 0", w);
    end
  endtask

  task automatic test_random();
    int w;
    sel = 0;
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_burst(AW'($urandom), 1'b0, '0, w);
    end
  endtask

  task automatic test_burst8();
    int w;
    sel = 1;
    do_burst(15'h0100, 1'b0, '0, w);
    do_burst(15'h7FFC, 1'b0, '0, w);
    for (int i = 0; i < 4; i++) begin
      do_burst(AW'($urandom), 1'b0, '0, w);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    sel       = 0;
    seed      = $urandom;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_burst8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
